// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
//   Groups the two handshakes of the instruction fetch queue:
//     - instruction memory side: req/addr out, ack/data back
//     - decode side: head instruction out with valid/ready, plus redirect in
//
//   master modport : the fetch queue itself
//   slave modport  : the environment (instruction memory + decode stage)
//
//   Signals
//     imem_req_o     fetch request outstanding
//     imem_addr_o    word-aligned fetch address
//     imem_ack_i     memory returns imem_data_i for the current request
//     imem_data_i    instruction word
//     redirect_i     flush queue and restart fetch at redirect_pc_i
//     redirect_pc_i  new fetch PC (bits [1:0] ignored)
//     instr_valid_o  queue head valid
//     instr_o        head instruction
//     instr_pc_o     head PC
//     instr_pc4_o    head PC+4
//     instr_ready_i  decode accepts the head this cycle
//     count_o        entries held, 0..DEPTH
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req_o;
  logic [31:0]   imem_addr_o;
  logic          imem_ack_i;
  logic [31:0]   imem_data_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          instr_valid_o;
  logic [31:0]   instr_o;
  logic [31:0]   instr_pc_o;
  logic [31:0]   instr_pc4_o;
  logic          instr_ready_i;
  logic [CW-1:0] count_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i,
    input  redirect_i,
    input  redirect_pc_i,
    output instr_valid_o,
    output instr_o,
    output instr_pc_o,
    output instr_pc4_o,
    input  instr_ready_i,
    output count_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i,
    output redirect_i,
    output redirect_pc_i,
    input  instr_valid_o,
    input  instr_o,
    input  instr_pc_o,
    input  instr_pc4_o,
    output instr_ready_i,
    input  count_o
  );

endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//   MIPS instruction fetch stage with a small prefetch buffer. Issues word
//   fetches to a variable-latency instruction memory over a req/ack
//   handshake, queues returned words together with their PC and PC+4, and
//   presents the queue head to decode over valid/ready. A redirect (branch,
//   jump, jr) flushes the queue and restarts fetch at the new PC.
//
//   Parameters
//     DEPTH     queue entries (power of 2, >= 2)
//     RESET_PC  first fetch address after reset (word aligned)
//
//   Ports
//     clk_i   clock, all state updates on the rising edge
//     rst_i   synchronous active-high reset
//     bus     instr_fetch_queue_if.master (memory + decode handshakes)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  instr_fetch_queue_if.master    bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  // Control state
  state_e        state_q,    state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;

  // Queue storage: plain data, written only on push, never reset
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];

  logic          head_vld;
  logic          pop;
  logic          push;
  logic [CW-1:0] cnt_n;
  logic [CW-1:0] cnt_after_pop;
  logic          room;
  logic [31:0]   redir_pc;
  logic [31:0]   req_addr_inc;

  assign head_vld      = (cnt_q != '0);

  // A redirect cycle neither consumes the head nor keeps a returning word.
  assign pop           = head_vld & bus.instr_ready_i & ~bus.redirect_i;
  assign push          = (state_q == S_REQ) & bus.imem_ack_i & ~bus.redirect_i;

  assign cnt_n         = cnt_q - CW'(pop) + CW'(push);
  assign cnt_after_pop = cnt_q - CW'(pop);

  // A new request is only started when the word it returns is guaranteed a
  // slot, so the queue can never overflow.
  assign room          = (cnt_after_pop < CW'(DEPTH));

  assign redir_pc      = bus.redirect_pc_i & ~32'h3;
  assign req_addr_inc  = req_addr_q + 32'd4;

  // -------------------------------------------------------------------------
  // Fetch FSM next-state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redir_pc;
        end else if (room) begin
          state_d    = S_REQ;
          req_addr_d = fetch_pc_q;
        end
      end

      S_REQ: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redir_pc;
          // Without an ack the bus transaction must still be completed
          // (address held stable); its word is thrown away in DROP.
          state_d    = bus.imem_ack_i ? S_IDLE : S_DROP;
        end else if (bus.imem_ack_i) begin
          fetch_pc_d = req_addr_inc;
          if (cnt_n < CW'(DEPTH)) begin
            state_d    = S_REQ;
            req_addr_d = req_addr_inc;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end

      S_DROP: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redir_pc;
        end
        if (bus.imem_ack_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Queue pointer / occupancy next-state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_n;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    if (bus.redirect_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.imem_data_i;
      pc_mem_q[wr_ptr_q]    <= req_addr_q;
      pc4_mem_q[wr_ptr_q]   <= req_addr_inc;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all driven from registers. The head fields read as zero while
  // the queue is empty so that the unreset storage never leaks out.
  // -------------------------------------------------------------------------
  assign bus.imem_req_o    = (state_q != S_IDLE);
  assign bus.imem_addr_o   = req_addr_q;
  assign bus.instr_valid_o = head_vld;
  assign bus.instr_o       = head_vld ? instr_mem_q[rd_ptr_q] : '0;
  assign bus.instr_pc_o    = head_vld ? pc_mem_q[rd_ptr_q]    : '0;
  assign bus.instr_pc4_o   = head_vld ? pc4_mem_q[rd_ptr_q]   : '0;
  assign bus.count_o       = cnt_q;

endmodule
